panda_load_seq: RTL and testbench
=================================

PANDA_LOAD_SEQ -- requirements
Module: panda_load_seq

Interface
REQ-001 Parameter LEN_W, default 16: width of per-section word counts and of the write offset.
REQ-002 Parameter TIMEOUT, default 1024: stall-cycle limit, used only when the Configuration macro is defined.
REQ-003 Port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_ni, input, 1: asynchronous active-low reset.
REQ-005 Port clear_i, input, 1: synchronous soft clear.
REQ-006 Port start_i, input, 1: single-cycle request to run one load sequence.
REQ-007 Port sec_en_i, input, 7: section enable; bit i selects mem_sel code i (0 config ... 6 weight FC).
REQ-008 Port sec_base_i, input, 7x32: per-section source base address, section i at bits [32i+31:32i].
REQ-009 Port sec_len_i, input, 7xLEN_W: per-section word count.
REQ-010 Port src_start_o, output, 1: one-cycle launch pulse to the source streamer.
REQ-011 Port src_addr_o, output, 32: base address of the current section.
REQ-012 Port src_len_o, output, LEN_W: word count of the current section.
REQ-013 Port stream_valid_i, input, 1: data word valid from the streamer.
REQ-014 Port stream_ready_o, output, 1: sequencer accepts the word.
REQ-015 Port mem_sel_o, output, 3: memory demux select; 7 (NULL) when no section is active.
REQ-016 Port wr_en_o, output, 1: memory write strobe.
REQ-017 Port waddr_o, output, LEN_W: word offset inside the current section.
REQ-018 Port busy_o, output, 1: high in every state other than IDLE.
REQ-019 Port done_o, output, 1: one-cycle end-of-sequence pulse.
REQ-020 Port err_o, output, 1: sticky timeout error.

Function
REQ-021 The FSM SHALL have the states IDLE, SELECT, LAUNCH, STREAM, NEXT and DONE.
REQ-022 IDLE: start_i=1 SHALL latch sec_en_i into en_q, clear idx to 0 and go to SELECT; start_i SHALL be ignored in all other states.
REQ-023 SELECT (one cycle) SHALL priority-encode the lowest i>=idx with en_q[i]=1 and sec_len_i[i]!=0; if one is found, idx becomes i and the FSM goes to LAUNCH, otherwise to DONE.
REQ-024 LAUNCH SHALL assert src_start_o for exactly one cycle with src_addr_o and src_len_o taken from section idx, clear the word counter and go to STREAM.
REQ-025 STREAM SHALL hold stream_ready_o=1; when stream_valid_i=1, wr_en_o SHALL be 1 in the same cycle with waddr_o equal to the counter, and the counter SHALL then increment.
REQ-026 The handshake accepted with counter = sec_len-1 SHALL move the FSM to NEXT; no word beyond sec_len SHALL be accepted.
REQ-027 NEXT SHALL set idx=idx+1 and go to SELECT; from idx=6 it SHALL go directly to DONE, with no wrap-around.
REQ-028 DONE SHALL assert done_o for one cycle and return to IDLE.
REQ-029 mem_sel_o SHALL equal idx in LAUNCH and STREAM, and 7 otherwise.
REQ-030 wr_en_o and stream_ready_o SHALL be 0 outside STREAM.
REQ-031 Latency: start_i sampled at edge T gives SELECT in cycle T+1 and src_start_o in cycle T+2.
REQ-032 sec_base_i and sec_len_i SHALL be held stable by the register file while busy_o=1; the block does not latch them.
REQ-033 clear_i SHALL take priority over every other event and return the block to IDLE with the counter, idx and en_q at 0 and err_o cleared, without pulsing done_o.

Reset
REQ-034 rst_ni low SHALL asynchronously force IDLE and set every output to 0, except mem_sel_o, which SHALL be 7.
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence; no done_o pulse SHALL follow.

Configuration
REQ-036 Macro PANDA_LOAD_SEQ_TIMEOUT_EN defined: a stall counter SHALL count STREAM cycles without a handshake, reset on each handshake; on reaching TIMEOUT it SHALL set err_o (sticky until clear_i or reset) and go to DONE.
REQ-037 Macro PANDA_LOAD_SEQ_TIMEOUT_EN undefined: no stall counter SHALL exist, err_o SHALL be tied to 0, and STREAM SHALL wait indefinitely.

Verification
REQ-038 sec_en_i=7'h01, len0=4, valid held high, start_i -> src_start_o in cycle T+2, four wr_en_o with waddr_o 0..3, mem_sel_o=0, then done_o one cycle later.
REQ-039 sec_en_i=7'h52, lens 2/3/1 on sections 1/4/6 -> sections launched in order 1, 4, 6 with mem_sel_o 1, 4, 6; 6 writes total; one done_o.
REQ-040 sec_en_i=7'h03, len0=0, len1=2 -> section 0 skipped with no src_start_o for it; only section 1 is written.
REQ-041 valid toggled 1,0,0,1,1 with len=3 -> wr_en_o only in the valid cycles; waddr_o 0,1,2.
REQ-042 clear_i pulse during STREAM of section 4 -> IDLE next cycle, mem_sel_o=7, no done_o; a new start_i is then accepted.
REQ-043 With PANDA_LOAD_SEQ_TIMEOUT_EN defined and TIMEOUT=8, valid held low -> err_o=1 after 8 stalled cycles, done_o pulses, and err_o stays 1 until clear_i.

Source files
------------

// File: rtl/panda_load_seq.sv
// Load sequencer: walks the enabled, non-empty sections in index order, launches the
// source streamer for each and writes its words into the selected memory. Optional stall
// timeout under macro PANDA_LOAD_SEQ_TIMEOUT_EN.
module panda_load_seq #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [6:0]                sec_en_i,
    input  logic [6:0][31:0]          sec_base_i,
    input  logic [6:0][LEN_W-1:0]     sec_len_i,
    output logic                      src_start_o,
    output logic [31:0]               src_addr_o,
    output logic [LEN_W-1:0]          src_len_o,
    input  logic                      stream_valid_i,
    output logic                      stream_ready_o,
    output logic [2:0]                mem_sel_o,
    output logic                      wr_en_o,
    output logic [LEN_W-1:0]          waddr_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       r_idx;
    logic [6:0]       r_en;
    logic [LEN_W-1:0] r_cnt;

    logic             w_found;
    logic [2:0]       w_sel_idx;
    logic             w_active;
    logic             w_hs;
    logic             w_last;
    logic             w_stall_hit;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = r_idx;
        for (int i = 6; i >= 0; i--) begin
            if (3'(i) >= r_idx && r_en[i] && sec_len_i[i] != '0) begin
                w_found   = 1'b1;
                w_sel_idx = 3'(i);
            end
        end
    end

    assign w_active = (r_state == S_LAUNCH) || (r_state == S_STREAM);
    assign w_hs     = (r_state == S_STREAM) && stream_valid_i;
    assign w_last   = (r_cnt == sec_len_i[r_idx] - LEN_W'(1));

`ifdef PANDA_LOAD_SEQ_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT + 1);
    logic [ST_W-1:0] r_stall;
    logic            r_err;

    assign w_stall_hit = (r_state == S_STREAM) && !stream_valid_i
                         && (r_stall == ST_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else if (clear_i) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state != S_STREAM || stream_valid_i)
                r_stall <= '0;
            else
                r_stall <= r_stall + ST_W'(1);
            if (w_stall_hit)
                r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign w_stall_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_en    <= '0;
            r_cnt   <= '0;
        end else if (clear_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_en    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_en    <= sec_en_i;
                    r_idx   <= '0;
                    r_state <= S_SELECT;
                end
                S_SELECT: begin
                    r_idx   <= w_sel_idx;
                    r_state <= w_found ? S_LAUNCH : S_DONE;
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_last) r_state <= S_NEXT;
                    end else if (w_stall_hit) begin
                        r_state <= S_DONE;
                    end
                end
                S_NEXT: begin
                    if (r_idx == 3'd6) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= S_SELECT;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign src_start_o    = (r_state == S_LAUNCH);
    assign src_addr_o     = w_active ? sec_base_i[r_idx] : 32'd0;
    assign src_len_o      = w_active ? sec_len_i[r_idx] : '0;
    assign stream_ready_o = (r_state == S_STREAM);
    assign wr_en_o        = w_hs;
    assign waddr_o        = (r_state == S_STREAM) ? r_cnt : '0;
    assign mem_sel_o      = w_active ? r_idx : 3'd7;
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = (r_state == S_DONE);

endmodule

// File: tb/tb_panda_load_seq.sv
// Directed bench for panda_load_seq: launches and writes are predicted into queues when
// stimulus is driven and checked by a negedge monitor as the DUT produces them.
module tb_panda_load_seq;

  localparam int LEN_W = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  clear_i = 1'b0;
  logic                  start_i = 1'b0;
  logic [6:0]            sec_en_i = '0;
  logic [6:0][31:0]      sec_base_i;
  logic [6:0][LEN_W-1:0] sec_len_i = '0;
  logic                  src_start_o;
  logic [31:0]           src_addr_o;
  logic [LEN_W-1:0]      src_len_o;
  logic                  stream_valid_i = 1'b0;
  logic                  stream_ready_o;
  logic [2:0]            mem_sel_o;
  logic                  wr_en_o;
  logic [LEN_W-1:0]      waddr_o;
  logic                  busy_o, done_o, err_o;

  panda_load_seq #(.LEN_W(LEN_W), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .sec_en_i(sec_en_i), .sec_base_i(sec_base_i), .sec_len_i(sec_len_i),
    .src_start_o(src_start_o), .src_addr_o(src_addr_o), .src_len_o(src_len_o),
    .stream_valid_i(stream_valid_i), .stream_ready_o(stream_ready_o),
    .mem_sel_o(mem_sel_o), .wr_en_o(wr_en_o), .waddr_o(waddr_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [2:0] sel; logic [31:0] addr; logic [LEN_W-1:0] len; } launch_t;
  typedef struct { logic [2:0] sel; logic [LEN_W-1:0] waddr; } wr_t;

  launch_t lq[$];
  wr_t     wq[$];
  launch_t ml;
  wr_t     mw;
  int      tests = 0;
  int      fails = 0;
  int      done_cnt = 0;
  int      snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (src_start_o) begin
      if (lq.size() == 0) chk("launch_unexpected", 1, 0);
      else begin
        ml = lq.pop_front();
        chk("launch_sel", 64'(mem_sel_o), 64'(ml.sel));
        chk("launch_addr", 64'(src_addr_o), 64'(ml.addr));
        chk("launch_len", 64'(src_len_o), 64'(ml.len));
      end
    end
    if (wr_en_o) begin
      chk("wr_ready", 64'(stream_ready_o), 1);
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        mw = wq.pop_front();
        chk("wr_sel", 64'(mem_sel_o), 64'(mw.sel));
        chk("wr_addr", 64'(waddr_o), 64'(mw.waddr));
      end
    end
  end

  task automatic expect_sec(input int s);
    launch_t l;
    wr_t w;
    l.sel = 3'(s); l.addr = sec_base_i[s]; l.len = sec_len_i[s];
    lq.push_back(l);
    for (int k = 0; k < int'(sec_len_i[s]); k++) begin
      w.sel = 3'(s); w.waddr = LEN_W'(k);
      wq.push_back(w);
    end
  endtask

  task automatic start_seq(input logic [6:0] en);
    @(posedge clk_i); #1 sec_en_i = en; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin @(negedge clk_i); n++; end
    chk({tag, "_done_seen"}, 64'(done_cnt >= target), 1);
    @(negedge clk_i);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'(target));
    chk({tag, "_idle_busy"}, 64'(busy_o), 0);
    chk({tag, "_idle_sel"}, 64'(mem_sel_o), 7);
    chk({tag, "_lq_empty"}, 64'(lq.size()), 0);
    chk({tag, "_wq_empty"}, 64'(wq.size()), 0);
  endtask

  task automatic wait_launch(input string tag);
    int n = 0;
    while (!src_start_o && n < 50) begin @(negedge clk_i); n++; end
    chk({tag, "_launch_seen"}, 64'(src_start_o), 1);
  endtask

  initial begin
    logic [4:0] pat;
    for (int i = 0; i < 7; i++) sec_base_i[i] = 32'h1000_0000 + 32'(i) * 32'h100;

    // Reset values
    #2;
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_sel", 64'(mem_sel_o), 7);
    chk("rst_outs", 64'({src_start_o, stream_ready_o, wr_en_o, done_o, err_o}), 0);
    chk("rst_data", 64'({src_addr_o, src_len_o, waddr_o}), 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // Single section, latency check
    sec_len_i = '0; sec_len_i[0] = 4; stream_valid_i = 1'b1;
    expect_sec(0);
    @(posedge clk_i); #1 sec_en_i = 7'h01; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    @(negedge clk_i);
    chk("lat_t1_busy", 64'(busy_o), 1);
    chk("lat_t1_start", 64'(src_start_o), 0);
    @(negedge clk_i);
    chk("lat_t2_start", 64'(src_start_o), 1);
    wait_done("t1", 1);

    // Three sparse sections
    sec_len_i = '0; sec_len_i[1] = 2; sec_len_i[4] = 3; sec_len_i[6] = 1;
    expect_sec(1); expect_sec(4); expect_sec(6);
    start_seq(7'h52);
    wait_done("t2", 2);

    // Empty section is skipped
    sec_len_i = '0; sec_len_i[1] = 2;
    expect_sec(1);
    start_seq(7'h03);
    wait_done("t3", 3);

    // Valid toggling
    stream_valid_i = 1'b0;
    sec_len_i = '0; sec_len_i[0] = 3;
    expect_sec(0);
    start_seq(7'h01);
    wait_launch("t4");
    pat = 5'b11001;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1 stream_valid_i = pat[k];
    end
    @(posedge clk_i); #1 stream_valid_i = 1'b0;
    wait_done("t4", 4);

    // Soft clear mid-stream of section 4
    sec_len_i = '0; sec_len_i[4] = 5;
    lq.push_back('{sel: 3'd4, addr: sec_base_i[4], len: 5});
    start_seq(7'h10);
    wait_launch("t5");
    repeat (2) @(posedge clk_i);
    #1 clear_i = 1'b1;
    @(posedge clk_i); #1 clear_i = 1'b0;
    @(negedge clk_i);
    chk("clr_busy", 64'(busy_o), 0);
    chk("clr_sel", 64'(mem_sel_o), 7);
    chk("clr_ready", 64'(stream_ready_o), 0);
    repeat (4) @(negedge clk_i);
    chk("clr_no_done", 64'(done_cnt), 4);
    chk("clr_err", 64'(err_o), 0);

    // Restart after clear
    sec_len_i = '0; sec_len_i[0] = 4; stream_valid_i = 1'b1;
    expect_sec(0);
    start_seq(7'h01);
    wait_done("t6", 5);

    // Asynchronous reset mid-stream
    stream_valid_i = 1'b0;
    sec_len_i = '0; sec_len_i[4] = 5;
    lq.push_back('{sel: 3'd4, addr: sec_base_i[4], len: 5});
    start_seq(7'h10);
    wait_launch("t7");
    @(posedge clk_i); #3 rst_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 0);
    chk("arst_sel", 64'(mem_sel_o), 7);
    chk("arst_ready", 64'(stream_ready_o), 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("arst_no_done", 64'(done_cnt), 5);

`ifdef PANDA_LOAD_SEQ_TIMEOUT_EN
    // Stall timeout with TIMEOUT=8
    sec_len_i = '0; sec_len_i[0] = 4;
    lq.push_back('{sel: 3'd0, addr: sec_base_i[0], len: 4});
    snap = done_cnt;
    start_seq(7'h01);
    wait_launch("t8");
    repeat (8) @(negedge clk_i);
    chk("to_err_before", 64'(err_o), 0);
    @(negedge clk_i);
    chk("to_err_set", 64'(err_o), 1);
    chk("to_done", 64'(done_o), 1);
    repeat (3) @(negedge clk_i);
    chk("to_err_sticky", 64'(err_o), 1);
    chk("to_idle", 64'(busy_o), 0);
    chk("to_done_once", 64'(done_cnt), 64'(snap + 1));
    @(posedge clk_i); #1 clear_i = 1'b1;
    @(posedge clk_i); #1 clear_i = 1'b0;
    @(negedge clk_i);
    chk("to_err_clr", 64'(err_o), 0);
`else
    snap = done_cnt;
    chk("no_to_err", 64'(err_o), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
